// File: rtl/objective_pkg.sv
// Fixed-point formats shared by the logistic unit and its training objective.
package objective_pkg;

  localparam int ACT_W = 8;   // unsigned Q0.8
  localparam int ERR_W = 16;  // signed Q8.8

  typedef logic        [ACT_W-1:0] activation_t;
  typedef logic signed [ERR_W-1:0] error_t;

endpackage

// File: rtl/objective.sv
// Training objective: pairs an activation with its target and emits 2*(a - t) as a Q8.8 error.
module objective
  import objective_pkg::*;
#(
  parameter int ACTIVATION_WIDTH = ACT_W,
  parameter int ERROR_WIDTH      = ERR_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          train,
  input  logic                          activation_valid,
  input  logic [ACTIVATION_WIDTH-1:0]   activation_data,
  output logic                          activation_ready,
  input  logic                          target_valid,
  input  logic [ACTIVATION_WIDTH-1:0]   target_data,
  output logic                          target_ready,
  output logic                          error_valid,
  output logic [ERROR_WIDTH-1:0]        error_data,
  input  logic                          error_ready
);

  typedef enum logic {COLLECT, EMIT} state_t;

  localparam int DW = ACTIVATION_WIDTH + 2;

  state_t                        state, state_nxt;
  logic                          alive;
  logic                          a_held, t_held, a_held_nxt, t_held_nxt;
  logic [ACTIVATION_WIDTH-1:0]   a_reg, t_reg, a_reg_nxt, t_reg_nxt;
  logic [ERROR_WIDTH-1:0]        err_nxt;
  logic                          a_fire, t_fire, a_have, t_have;
  logic [ACTIVATION_WIDTH-1:0]   a_val, t_val;
  logic signed [DW-1:0]          diff;

  // alive keeps readies low in the cycle reset is released, rising on the first edge after it.
  assign activation_ready = alive && (state == COLLECT) && !a_held;
  assign target_ready     = alive && (state == COLLECT) && !t_held;
  assign error_valid      = (state == EMIT);

  assign a_fire = activation_valid && activation_ready;
  assign t_fire = target_valid && target_ready;
  assign a_have = a_held || a_fire;
  assign t_have = t_held || t_fire;
  assign a_val  = a_held ? a_reg : activation_data;
  assign t_val  = t_held ? t_reg : target_data;
  assign diff   = $signed({2'b00, a_val}) - $signed({2'b00, t_val});

  // A pair completing on this edge (held or arriving) is resolved immediately, giving two-cycle throughput.
  always_comb begin
    state_nxt  = state;
    a_held_nxt = a_held;
    t_held_nxt = t_held;
    a_reg_nxt  = a_reg;
    t_reg_nxt  = t_reg;
    err_nxt    = error_data;
    case (state)
      COLLECT: begin
        if (a_fire) begin
          a_held_nxt = 1'b1;
          a_reg_nxt  = activation_data;
        end
        if (t_fire) begin
          t_held_nxt = 1'b1;
          t_reg_nxt  = target_data;
        end
        if (a_have && t_have) begin
          a_held_nxt = 1'b0;
          t_held_nxt = 1'b0;
          if (train) begin
            state_nxt = EMIT;
            err_nxt   = {{(ERROR_WIDTH-DW-1){diff[DW-1]}}, diff, 1'b0};
          end
        end
      end
      EMIT: begin
        if (error_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= COLLECT;
      alive      <= 1'b0;
      a_held     <= 1'b0;
      t_held     <= 1'b0;
      a_reg      <= '0;
      t_reg      <= '0;
      error_data <= '0;
    end else begin
      state      <= state_nxt;
      alive      <= 1'b1;
      a_held     <= a_held_nxt;
      t_held     <= t_held_nxt;
      a_reg      <= a_reg_nxt;
      t_reg      <= t_reg_nxt;
      error_data <= err_nxt;
    end
  end

endmodule
